// File: rtl/spram_be_pipe_if.sv
// Request/response bundle for spram_be_pipe: one request per cycle while ready=1.
interface spram_be_pipe_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  en;
    logic                  write_en;
    logic [BE_WIDTH-1:0]   byte_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  ready;

    // Client side: issues requests, receives read results.
    modport master (
        output en, write_en, byte_en, addr, write_data,
        input  read_data, read_valid, ready
    );

    // Memory side: accepts requests, returns read results.
    modport slave (
        input  en, write_en, byte_en, addr, write_data,
        output read_data, read_valid, ready
    );
endinterface

// File: rtl/spram_be_pipe.sv
// Single-port synchronous RAM with byte-lane write enables, 1/2-cycle read
// latency, selectable read-during-write behaviour and a post-reset clear pass.
module spram_be_pipe #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input logic            clk,
    input logic            reset,
    spram_be_pipe_if.slave bus
);
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    // Elaboration-time parameter legality checks.
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("spram_be_pipe: DATA_WIDTH must be a multiple of 8");
    end
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
        $error("spram_be_pipe: RD_LATENCY must be 1 or 2");
    end
    if (RDW_MODE > 2) begin : g_bad_rdw
        $error("spram_be_pipe: RDW_MODE must be 0, 1 or 2");
    end

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_valid_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_acc_c;
    logic                  rd_acc_c;
    logic [DATA_WIDTH-1:0] old_word_c;
    logic [DATA_WIDTH-1:0] merged_c;
    logic                  r1_fire_c;
    logic [DATA_WIDTH-1:0] r1_data_c;

    assign bus.ready      = ready_q;
    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;

    // Request acceptance; ready is only ever high in IDLE.
    assign wr_acc_c   = bus.en & ready_q & bus.write_en;
    assign rd_acc_c   = bus.en & ready_q & ~bus.write_en;
    assign old_word_c = mem[bus.addr];

    // Lane merge: keep old bytes where byte_en is clear.
    always_comb begin
        merged_c = old_word_c;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (bus.byte_en[i]) begin
                merged_c[8*i +: 8] = bus.write_data[8*i +: 8];
            end
        end
    end

    // First read stage source: reads, plus writes in read-first/write-first modes.
    always_comb begin
        r1_fire_c = rd_acc_c | (wr_acc_c & (RDW_MODE != 2));
        r1_data_c = old_word_c;
        if (wr_acc_c && (RDW_MODE == 1)) begin
            r1_data_c = merged_c;
        end
    end

    // Control FSM: reset hold, optional clear sweep, then service requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RST;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    cnt <= '0;
                    if (CLEAR_ON_RESET != 0) begin
                        state   <= ST_CLEAR;
                        ready_q <= 1'b0;
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(DEPTH - 1)) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_RST;
                    cnt     <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage: clear sweep or accepted write; nothing lands on a reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[cnt[ADDR_WIDTH-1:0]] <= '0;
            end else if (wr_acc_c) begin
                mem[bus.addr] <= merged_c;
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        // Single-stage read: result registered straight onto the outputs.
        always_ff @(posedge clk) begin
            if (reset) begin
                read_valid_q <= 1'b0;
                read_data_q  <= '0;
            end else begin
                read_valid_q <= r1_fire_c;
                if (r1_fire_c) begin
                    read_data_q <= r1_data_c;
                end
            end
        end
    end else begin : g_lat2
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_data;

        // Two-stage read: stage 1 captures, output stage reloads each cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_valid     <= 1'b0;
                s1_data      <= '0;
                read_valid_q <= 1'b0;
                read_data_q  <= '0;
            end else begin
                s1_valid     <= r1_fire_c;
                s1_data      <= r1_data_c;
                read_valid_q <= s1_valid;
                if (s1_valid) begin
                    read_data_q <= s1_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_spram_be_pipe.sv
// Directed bench: four RAM variants (RDW 0/1/2 at latency 1, RDW 0 at latency 2)
// fed identical stimulus and checked against hand-computed vectors.
module tb_spram_be_pipe;
    logic        clk;
    logic        reset;
    logic        en;
    logic        write_en;
    logic [1:0]  byte_en;
    logic [7:0]  addr;
    logic [15:0] write_data;

    int checks = 0;
    int errors = 0;

    spram_be_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if0 ();
    spram_be_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if1 ();
    spram_be_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if2 ();
    spram_be_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if3 ();

    assign if0.en = en; assign if0.write_en = write_en; assign if0.byte_en = byte_en;
    assign if0.addr = addr; assign if0.write_data = write_data;
    assign if1.en = en; assign if1.write_en = write_en; assign if1.byte_en = byte_en;
    assign if1.addr = addr; assign if1.write_data = write_data;
    assign if2.en = en; assign if2.write_en = write_en; assign if2.byte_en = byte_en;
    assign if2.addr = addr; assign if2.write_data = write_data;
    assign if3.en = en; assign if3.write_en = write_en; assign if3.byte_en = byte_en;
    assign if3.addr = addr; assign if3.write_data = write_data;

    spram_be_pipe #(.RD_LATENCY(1), .RDW_MODE(0)) d0 (.clk(clk), .reset(reset), .bus(if0));
    spram_be_pipe #(.RD_LATENCY(1), .RDW_MODE(1)) d1 (.clk(clk), .reset(reset), .bus(if1));
    spram_be_pipe #(.RD_LATENCY(1), .RDW_MODE(2)) d2 (.clk(clk), .reset(reset), .bus(if2));
    spram_be_pipe #(.RD_LATENCY(2), .RDW_MODE(0)) d3 (.clk(clk), .reset(reset), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        we;
        logic [1:0]  be;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic [2:0]  ev;   // expected read_valid, bit i = RDW mode i
        logic [15:0] ed0;
        logic [15:0] ed1;
        logic [15:0] ed2;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vt [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic w, input logic [1:0] b,
                         input logic [7:0] a, input logic [15:0] d);
        en = e; write_en = w; byte_en = b; addr = a; write_data = d;
    endtask

    task automatic wait_ready(output int zeros);
        zeros = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (if0.ready) break;
            zeros++;
        end
    endtask

    initial begin
        int zeros;
        logic        pv;
        logic [15:0] pd;

        vt[0]  = '{1'b1, 1'b0, 2'b11, 8'hFF, 16'h0000, 3'b111, 16'h0000, 16'h0000, 16'h0000};
        vt[1]  = '{1'b1, 1'b1, 2'b11, 8'h12, 16'hABCD, 3'b011, 16'h0000, 16'hABCD, 16'h0000};
        vt[2]  = '{1'b1, 1'b1, 2'b01, 8'h12, 16'h1234, 3'b011, 16'hABCD, 16'hAB34, 16'h0000};
        vt[3]  = '{1'b1, 1'b0, 2'b00, 8'h12, 16'h0000, 3'b111, 16'hAB34, 16'hAB34, 16'hAB34};
        vt[4]  = '{1'b1, 1'b1, 2'b00, 8'h12, 16'hFFFF, 3'b011, 16'hAB34, 16'hAB34, 16'hAB34};
        vt[5]  = '{1'b1, 1'b0, 2'b00, 8'h12, 16'h0000, 3'b111, 16'hAB34, 16'hAB34, 16'hAB34};
        vt[6]  = '{1'b1, 1'b1, 2'b11, 8'h12, 16'h5678, 3'b011, 16'hAB34, 16'h5678, 16'hAB34};
        vt[7]  = '{1'b0, 1'b1, 2'b11, 8'h20, 16'hBEEF, 3'b000, 16'hAB34, 16'h5678, 16'hAB34};
        vt[8]  = '{1'b1, 1'b0, 2'b00, 8'h20, 16'h0000, 3'b111, 16'h0000, 16'h0000, 16'h0000};
        vt[9]  = '{1'b0, 1'b0, 2'b00, 8'h12, 16'h0000, 3'b000, 16'h0000, 16'h0000, 16'h0000};
        vt[10] = '{1'b1, 1'b1, 2'b11, 8'h01, 16'h0101, 3'b011, 16'h0000, 16'h0101, 16'h0000};
        vt[11] = '{1'b1, 1'b1, 2'b11, 8'h02, 16'h0202, 3'b011, 16'h0000, 16'h0202, 16'h0000};
        vt[12] = '{1'b1, 1'b1, 2'b11, 8'h03, 16'h0303, 3'b011, 16'h0000, 16'h0303, 16'h0000};
        vt[13] = '{1'b1, 1'b0, 2'b00, 8'h01, 16'h0000, 3'b111, 16'h0101, 16'h0101, 16'h0101};
        vt[14] = '{1'b1, 1'b0, 2'b00, 8'h02, 16'h0000, 3'b111, 16'h0202, 16'h0202, 16'h0202};
        vt[15] = '{1'b1, 1'b0, 2'b00, 8'h03, 16'h0000, 3'b111, 16'h0303, 16'h0303, 16'h0303};
        vt[16] = '{1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 3'b000, 16'h0303, 16'h0303, 16'h0303};
        vt[17] = '{1'b1, 1'b1, 2'b10, 8'h07, 16'h9A9A, 3'b011, 16'h0000, 16'h9A00, 16'h0303};
        vt[18] = '{1'b1, 1'b0, 2'b00, 8'h07, 16'h0000, 3'b111, 16'h9A00, 16'h9A00, 16'h9A00};
        vt[19] = '{1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 3'b000, 16'h9A00, 16'h9A00, 16'h9A00};

        // Reset held for two edges, then released into the clear sweep.
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        step();
        step();
        chk("rst_ready", 32'(if0.ready), 0);
        chk("rst_valid", 32'(if0.read_valid), 0);
        chk("rst_data", 32'(if0.read_data), 0);
        chk("rst_ready_lat2", 32'(if3.ready), 0);
        reset = 1'b0;
        wait_ready(zeros);
        chk("clear_ready_zeros", zeros, 256);
        chk("clear_ready_lat2", 32'(if3.ready), 1);

        // Vector table: lat-1 variants compared per row, lat-2 one row behind.
        pv = 1'b0;
        pd = 16'h0000;
        for (int k = 0; k < NVEC; k++) begin
            drive(vt[k].en, vt[k].we, vt[k].be, vt[k].addr, vt[k].wd);
            step();
            chk($sformatf("v%0d_m0_valid", k), 32'(if0.read_valid), 32'(vt[k].ev[0]));
            chk($sformatf("v%0d_m0_data", k), 32'(if0.read_data), 32'(vt[k].ed0));
            chk($sformatf("v%0d_m1_valid", k), 32'(if1.read_valid), 32'(vt[k].ev[1]));
            chk($sformatf("v%0d_m1_data", k), 32'(if1.read_data), 32'(vt[k].ed1));
            chk($sformatf("v%0d_m2_valid", k), 32'(if2.read_valid), 32'(vt[k].ev[2]));
            chk($sformatf("v%0d_m2_data", k), 32'(if2.read_data), 32'(vt[k].ed2));
            chk($sformatf("v%0d_lat2_valid", k), 32'(if3.read_valid), 32'(pv));
            chk($sformatf("v%0d_lat2_data", k), 32'(if3.read_data), 32'(pd));
            pv = vt[k].ev[0];
            pd = vt[k].ed0;
        end

        // Reset while a latency-2 read is in flight: flushed, no strobe.
        drive(1'b1, 1'b0, 2'b00, 8'h03, 16'h0000);
        step();
        chk("flush_lat1_valid", 32'(if0.read_valid), 1);
        chk("flush_lat1_data", 32'(if0.read_data), 32'h0303);
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        step();
        chk("flush_lat2_valid", 32'(if3.read_valid), 0);
        chk("flush_lat2_data", 32'(if3.read_data), 0);
        chk("flush_ready", 32'(if0.ready), 0);

        // Clear sweep interrupted near count 100; requests during clear ignored.
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50)      drive(1'b1, 1'b1, 2'b11, 8'h05, 16'hFFFF);
            else if (i == 60) drive(1'b1, 1'b0, 2'b00, 8'h03, 16'h0000);
            else              drive(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
            step();
            if (i == 60) chk("clear_read_ignored", 32'(if0.read_valid), 0);
            if (i == 99) chk("clear_mid_ready", 32'(if0.ready), 0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready(zeros);
        chk("reclear_ready_zeros", zeros, 256);
        drive(1'b1, 1'b0, 2'b00, 8'h05, 16'h0000);
        step();
        chk("reclear_m0_valid", 32'(if0.read_valid), 1);
        chk("reclear_m0_data", 32'(if0.read_data), 0);
        chk("reclear_m1_data", 32'(if1.read_data), 0);
        drive(1'b1, 1'b0, 2'b00, 8'h03, 16'h0000);
        step();
        chk("reclear_addr3_data", 32'(if0.read_data), 0);
        drive(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        step();
        chk("reclear_lat2_data", 32'(if3.read_data), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
